// File: rtl/alu_seq_ctrl.sv
// Byte-serial sequencer for an external 8-bit combinational ALU: takes one wide
// request, walks it LSB byte first with carry/borrow fix-up, returns the wide result.
module alu_seq_ctrl #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_cmd,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_y,
  output logic                  rsp_z,
  output logic                  rsp_c,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [1:0]            alu_cmd,
  input  logic [7:0]            alu_y,
  input  logic                  alu_z,
  input  logic                  alu_c
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRI  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, y_q, y_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [IW-1:0]   i_q, i_d;
  logic            cy_q, cy_d, c1_q, c1_d, zacc_q, zacc_d;
  logic [7:0]      t_q, t_d;

  logic [7:0]      a_byte, b_byte;
  logic            arith, last;

  assign a_byte = a_q[{i_q, 3'b000} +: 8];
  assign b_byte = b_q[{i_q, 3'b000} +: 8];
  // cmd[1]==0 selects ADD/SUB, cmd[0] distinguishes SUB within that pair
  assign arith  = ~cmd_q[1];
  assign last   = (i_q == IW'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      cmd_q   <= 2'b00;
      i_q     <= '0;
      cy_q    <= 1'b0;
      c1_q    <= 1'b0;
      zacc_q  <= 1'b0;
      t_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      cmd_q   <= cmd_d;
      i_q     <= i_d;
      cy_q    <= cy_d;
      c1_q    <= c1_d;
      zacc_q  <= zacc_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    y_d       = y_q;
    cmd_d     = cmd_q;
    i_d       = i_q;
    cy_d      = cy_q;
    c1_d      = c1_q;
    zacc_d    = zacc_q;
    t_d       = t_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_y     = '0;
    rsp_z     = 1'b0;
    rsp_c     = 1'b0;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_cmd   = 2'b00;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          cmd_d   = req_cmd;
          y_d     = '0;
          i_d     = '0;
          cy_d    = 1'b0;
          zacc_d  = 1'b1;
          state_d = PRI;
        end
      end

      PRI: begin
        alu_a   = a_byte;
        alu_b   = b_byte;
        alu_cmd = cmd_q;
        t_d     = alu_y;
        if (arith) begin
          // the ALU has no borrow output, so SUB derives it from the operands
          c1_d    = cmd_q[0] ? (a_byte < b_byte) : alu_c;
          state_d = FIX;
        end else begin
          y_d[{i_q, 3'b000} +: 8] = alu_y;
          zacc_d = zacc_q & alu_z;
          if (last) state_d = DONE;
          else      i_d     = i_q + IW'(1);
        end
      end

      FIX: begin
        alu_a   = t_q;
        alu_b   = {7'b0, cy_q};
        alu_cmd = cmd_q;
        y_d[{i_q, 3'b000} +: 8] = alu_y;
        zacc_d  = zacc_q & alu_z;
        cy_d    = cmd_q[0] ? (c1_q | (cy_q & (t_q == 8'h00))) : (c1_q | alu_c);
        if (last) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = PRI;
        end
      end

      DONE: begin
        rsp_valid = 1'b1;
        rsp_y     = y_q;
        rsp_z     = zacc_q;
        rsp_c     = arith & cy_q;
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl (NBYTES=2) with a behavioural 8-bit ALU beside it.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]  req_cmd;
  logic [15:0] req_a, req_b, rsp_y;
  logic        rsp_z, rsp_c;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic [1:0]  alu_cmd;
  logic        alu_z, alu_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NBYTES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_c(rsp_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_y(alu_y), .alu_z(alu_z), .alu_c(alu_c)
  );

  // reference ALU: carry only meaningful for ADD
  logic [8:0] sum9;
  always_comb begin
    sum9  = {1'b0, alu_a} + {1'b0, alu_b};
    alu_c = 1'b0;
    case (alu_cmd)
      2'b00:   begin alu_y = sum9[7:0]; alu_c = sum9[8]; end
      2'b01:   alu_y = alu_a - alu_b;
      2'b10:   alu_y = alu_a | alu_b;
      default: alu_y = alu_a & alu_b;
    endcase
    alu_z = (alu_y == 8'h00);
  end

  // drives one request and waits for the response; ack=0 leaves it pending
  task automatic issue(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b,
                       input bit ack, output int lat, output logic [15:0] y,
                       output logic z, output logic c, output bit to);
    int n;
    to = 1'b0; lat = 0; y = '0; z = 1'b0; c = 1'b0;
    @(negedge clk);
    req_cmd = cmd; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin to = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    to = !rsp_valid;
    y = rsp_y; z = rsp_z; c = rsp_c;
    if (ack && !to) begin
      @(negedge clk); rsp_ready = 1'b1;
      @(posedge clk); #1; rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_cmd = 2'b00; req_a = '0; req_b = '0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_y !== 16'h0 || rsp_z !== 1'b0 ||
        rsp_c !== 1'b0 || alu_a !== 8'h0 || alu_b !== 8'h0 || alu_cmd !== 2'b00) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b y=%h z=%b c=%b a=%h b=%h cmd=%b, required 1 0 0000 0 0 00 00 00",
               req_ready, rsp_valid, rsp_y, rsp_z, rsp_c, alu_a, alu_b, alu_cmd);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [15:0] ta[3] = '{16'h00FF, 16'hFFFF, 16'h8000};
    logic [15:0] tb[3] = '{16'h0001, 16'h0001, 16'h8000};
    logic [15:0] ey[3] = '{16'h0100, 16'h0000, 16'h0000};
    logic        ez[3] = '{1'b0, 1'b1, 1'b1};
    logic        ec[3] = '{1'b0, 1'b1, 1'b1};
    int lat; logic [15:0] y; logic z, c; bit to;
    for (int k = 0; k < 3; k++) begin
      issue(2'b00, ta[k], tb[k], 1'b1, lat, y, z, c, to);
      checks++;
      if (to || lat != 4 || y !== ey[k] || z !== ez[k] || c !== ec[k]) begin
        errors++;
        $display("FAIL add%0d: to=%b lat=%0d y=%h z=%b c=%b, required lat=4 y=%h z=%b c=%b",
                 k, to, lat, y, z, c, ey[k], ez[k], ec[k]);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] ta[3] = '{16'h0100, 16'h0000, 16'h1234};
    logic [15:0] tb[3] = '{16'h0001, 16'h0001, 16'h1234};
    logic [15:0] ey[3] = '{16'h00FF, 16'hFFFF, 16'h0000};
    logic        ez[3] = '{1'b0, 1'b0, 1'b1};
    logic        ec[3] = '{1'b0, 1'b1, 1'b0};
    int lat; logic [15:0] y; logic z, c; bit to;
    for (int k = 0; k < 3; k++) begin
      issue(2'b01, ta[k], tb[k], 1'b1, lat, y, z, c, to);
      checks++;
      if (to || lat != 4 || y !== ey[k] || z !== ez[k] || c !== ec[k]) begin
        errors++;
        $display("FAIL sub%0d: to=%b lat=%0d y=%h z=%b c=%b, required lat=4 y=%h z=%b c=%b",
                 k, to, lat, y, z, c, ey[k], ez[k], ec[k]);
      end
    end
  endtask

  task automatic test_logic();
    int lat; logic [15:0] y; logic z, c; bit to;
    issue(2'b10, 16'hF00F, 16'h0FF0, 1'b1, lat, y, z, c, to);
    checks++;
    if (to || lat != 2 || y !== 16'hFFFF || z !== 1'b0 || c !== 1'b0) begin
      errors++;
      $display("FAIL or: to=%b lat=%0d y=%h z=%b c=%b, required lat=2 y=ffff z=0 c=0", to, lat, y, z, c);
    end
    issue(2'b11, 16'hF00F, 16'h0FF0, 1'b1, lat, y, z, c, to);
    checks++;
    if (to || lat != 2 || y !== 16'h0000 || z !== 1'b1 || c !== 1'b0) begin
      errors++;
      $display("FAIL and: to=%b lat=%0d y=%h z=%b c=%b, required lat=2 y=0000 z=1 c=0", to, lat, y, z, c);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] y; logic z, c; bit to;
    issue(2'b00, 16'h0FFF, 16'h0001, 1'b0, lat, y, z, c, to);
    checks++;
    if (to || lat != 4 || y !== 16'h1000) begin
      errors++;
      $display("FAIL bp_first: to=%b lat=%0d y=%h, required lat=4 y=1000", to, lat, y);
    end
    @(negedge clk);
    req_cmd = 2'b10; req_a = 16'h1200; req_b = 16'h0034; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== 16'h1000 || rsp_z !== 1'b0 || rsp_c !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b y=%h z=%b c=%b rdy=%b, required 1 1000 0 0 0",
                 k, rsp_valid, rsp_y, rsp_z, rsp_c, req_ready);
      end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b, required vld=0 rdy=1", rsp_valid, req_ready);
    end
    @(posedge clk); #1; req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept2: rdy=%b vld=%b, required rdy=0 vld=0", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_lat2: vld=%b one cycle early, required 0", rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 16'h1234 || rsp_z !== 1'b0 || rsp_c !== 1'b0) begin
      errors++;
      $display("FAIL bp_second: vld=%b y=%h z=%b c=%b, required 1 1234 0 0", rsp_valid, rsp_y, rsp_z, rsp_c);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_abort();
    int lat; logic [15:0] y; logic z, c; bit to;
    bit seen;
    @(negedge clk);
    req_cmd = 2'b01; req_a = 16'h0100; req_b = 16'h0001; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    // byte 0 FIX of 0x00-0x01: t=0xFF, borrow-in 0
    checks++;
    if (alu_a !== 8'hFF || alu_b !== 8'h00 || alu_cmd !== 2'b01) begin
      errors++;
      $display("FAIL abort_fix: a=%h b=%h cmd=%b, required ff 00 01", alu_a, alu_b, alu_cmd);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_y !== 16'h0 || rsp_z !== 1'b0 ||
        rsp_c !== 1'b0 || alu_a !== 8'h0 || alu_b !== 8'h0 || alu_cmd !== 2'b00) begin
      errors++;
      $display("FAIL abort_reset: rdy=%b vld=%b y=%h z=%b c=%b a=%h b=%h cmd=%b, required 1 0 0000 0 0 00 00 00",
               req_ready, rsp_valid, rsp_y, rsp_z, rsp_c, alu_a, alu_b, alu_cmd);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_norsp: rsp_valid seen=%b after abort, required 0", seen);
    end
    issue(2'b00, 16'h00FF, 16'h0001, 1'b1, lat, y, z, c, to);
    checks++;
    if (to || lat != 4 || y !== 16'h0100 || z !== 1'b0 || c !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: to=%b lat=%0d y=%h z=%b c=%b, required lat=4 y=0100 z=0 c=0",
               to, lat, y, z, c);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
